data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data port: accepts one load/store request at a time over a valid/ready channel.
- Models a configurable access latency and returns load data, or a store acknowledgement, over a valid/ready response channel.
- Implements RV32I byte/half/word access semantics selected by funct3, on a little-endian byte array.
- Replaces the combinational data memory when the core moves to a handshaked memory interface.

Parameters:
- ADDR_BITS, 12, byte-address width of the internal array (2^ADDR_BITS bytes).
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  in  3  RV32I load/store funct3
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal-funct3 access

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, latency counter=0. Array contents are not reset.
- All outputs are registered.
- State machine:
  - IDLE: req_ready=1. On req_valid && req_ready, capture we/addr/wdata/funct3, load the counter with LATENCY-1, drop req_ready, go to BUSY.
  - BUSY: req_ready=0. When the counter is 0, perform the access, register rsp_rdata/rsp_err, raise rsp_valid, go to RESP. Otherwise decrement.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable. On rsp_valid && rsp_ready, drop rsp_valid, raise req_ready, go to IDLE.
- Latency: with acceptance on edge T, rsp_valid is 1 in the cycle following edge T+LATENCY.
- Minimum request-to-request spacing is LATENCY+2 cycles when rsp_ready is held high. Only one request is outstanding at a time; there is no pipelining.
- Loads:
  - funct3 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Little-endian: addr+0 is the LSB.
- Stores:
  - 000 SB: write 1 byte.
  - 001 SH: write 2 bytes.
  - 010 SW: write 4 bytes.
  - Bytes are written on the edge that raises rsp_valid. rsp_rdata=0 on a store response.
- Errors: rsp_err=1, rsp_rdata=0, no array write, same latency as a normal access. An access errors when any of these holds:
  - halfword with addr[0]!=0;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_BITS]!=0;
  - illegal funct3: load 011/110/111, or store with funct3 other than 000/001/010.
- Requests in flight:
  - req_valid while req_ready=0 is ignored; the requester must hold the request.
  - Input changes after acceptance have no effect.
- Response backpressure: rsp_ready low holds RESP indefinitely. rsp_ready while rsp_valid=0 has no effect.
- Read-after-write: a load accepted after a store response returns the stored data.
- Reset mid-operation: rst in BUSY or RESP aborts the transaction and returns to the reset values.
  - A store not yet committed (rst asserted on or before the commit edge) leaves the array unchanged.
  - A store already committed stays committed.
- LATENCY=1: BUSY lasts exactly one cycle (counter loaded with 0).

Test Plan:
- Word round trip:
  - SW 0xDEADBEEF to 0x100, rsp_ready=1. Expect rsp_valid exactly LATENCY cycles after acceptance, err=0, rdata=0.
  - LW 0x100. Expect rdata=0xDEADBEEF.
- Sub-word loads: after the store above:
  - LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE.
  - LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF.
- Partial stores: SB 0x12 to 0x101, then SH 0x7654 to 0x102, then LW 0x100 -> 0x765412EF.
- Errors: each of these gives err=1, rdata=0 at normal latency, and a following LW 0x100 still reads 0x765412EF:
  - LW at 0x102;
  - LH at 0x101;
  - SW 0x0 to 0x10000 (with ADDR_BITS=12);
  - load with funct3=011.
- Backpressure and ignored request:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid. rsp_valid and rdata must stay stable, and req_ready must stay 0.
  - A second req_valid during that window is not accepted.
  - Raising rsp_ready gives req_ready=1 on the next cycle.
- Reset mid-store:
  - SW 0x11111111 to 0x200, with rst asserted one cycle after acceptance (LATENCY=2).
  - Next cycle: req_ready=1, rsp_valid=0.
  - A subsequent LW 0x200 returns the pre-existing value (preload 0x0 -> 0x00000000).

Source files
------------

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle for the data memory port
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-modelling RV32I data memory behind valid/ready channels
module data_mem_responder #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q, we_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [2:0]  f3_q, f3_nxt;
  logic        req_ready_q, req_ready_nxt;
  logic        rsp_valid_q, rsp_valid_nxt;
  logic [31:0] rsp_rdata_q, rsp_rdata_nxt;
  logic        rsp_err_q, rsp_err_nxt;

  logic [7:0]  mem [0:(1 << ADDR_BITS) - 1];

  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic        misaligned, out_of_range, bad_funct3, acc_err;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic        commit;

  // Byte lanes of the captured access; little-endian, lane 0 is the addressed byte.
  assign a0 = addr_q[ADDR_BITS-1:0];
  assign a1 = a0 + ADDR_BITS'(1);
  assign a2 = a0 + ADDR_BITS'(2);
  assign a3 = a0 + ADDR_BITS'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Classify the captured access: alignment, range and funct3 legality.
  always_comb begin
    misaligned = 1'b0;
    case (f3_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    out_of_range = |addr_q[31:ADDR_BITS];
    if (we_q) begin
      bad_funct3 = f3_q[2] || (f3_q[1:0] == 2'b11);
    end else begin
      bad_funct3 = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
    end
    acc_err = misaligned || out_of_range || bad_funct3;
  end

  // Load extraction and store byte enables selected by funct3.
  always_comb begin
    load_data = 32'h0;
    byte_en   = 4'b0000;
    case (f3_q)
      3'b000: begin
        load_data = {{24{b0[7]}}, b0};
        byte_en   = 4'b0001;
      end
      3'b001: begin
        load_data = {{16{b1[7]}}, b1, b0};
        byte_en   = 4'b0011;
      end
      3'b010: begin
        load_data = {b3, b2, b1, b0};
        byte_en   = 4'b1111;
      end
      3'b100:  load_data = {24'h0, b0};
      3'b101:  load_data = {16'h0, b1, b0};
      default: begin
        load_data = 32'h0;
        byte_en   = 4'b0000;
      end
    endcase
  end

  // A store lands on the edge that raises rsp_valid; a reset on that edge suppresses it.
  assign commit = (state == BUSY) && (cnt == 4'd0) && we_q && !acc_err && !rst;

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (byte_en[0]) mem[a0] <= wdata_q[7:0];
      if (byte_en[1]) mem[a1] <= wdata_q[15:8];
      if (byte_en[2]) mem[a2] <= wdata_q[23:16];
      if (byte_en[3]) mem[a3] <= wdata_q[31:24];
    end
  end

  // Next-state and next-output logic; everything holds unless a transition says otherwise.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    we_nxt        = we_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    f3_nxt        = f3_q;
    req_ready_nxt = req_ready_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_err_nxt   = rsp_err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_nxt        = bus.req_we;
          addr_nxt      = bus.req_addr;
          wdata_nxt     = bus.req_wdata;
          f3_nxt        = bus.req_funct3;
          cnt_nxt       = CNT_LOAD;
          req_ready_nxt = 1'b0;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          rsp_rdata_nxt = (we_q || acc_err) ? 32'h0 : load_data;
          rsp_err_nxt   = acc_err;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      f3_q        <= 3'b000;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      we_q        <= we_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      f3_q        <= f3_nxt;
      req_ready_q <= req_ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
  localparam int LAT = 2;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.ADDR_BITS(12), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present a request and return just after its acceptance edge, then scramble the inputs.
  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
    int n = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = addr ^ 32'h4;
    bus.req_wdata  = ~wdata;
    bus.req_funct3 = 3'b111;
  endtask

  // Count edges after acceptance until rsp_valid is seen.
  task automatic wait_rsp(output logic [31:0] rdata, output logic err, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3,
                     input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    start_req(we, addr, wdata, f3);
    wait_rsp(rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  // Stimulus sequence.
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;

    run("sw_word", 1'b1, 32'h100, 32'hDEADBEEF, F_W, 32'h0, 1'b0);
    run("lw_word", 1'b0, 32'h100, 32'h0, F_W, 32'hDEADBEEF, 1'b0);
    run("lb_103", 1'b0, 32'h103, 32'h0, F_B, 32'hFFFFFFDE, 1'b0);
    run("lbu_103", 1'b0, 32'h103, 32'h0, F_BU, 32'h000000DE, 1'b0);
    run("lh_102", 1'b0, 32'h102, 32'h0, F_H, 32'hFFFFDEAD, 1'b0);
    run("lhu_100", 1'b0, 32'h100, 32'h0, F_HU, 32'h0000BEEF, 1'b0);

    run("sb_101", 1'b1, 32'h101, 32'hFFFFFF12, F_B, 32'h0, 1'b0);
    run("sh_102", 1'b1, 32'h102, 32'hAAAA7654, F_H, 32'h0, 1'b0);
    run("lw_partial", 1'b0, 32'h100, 32'h0, F_W, 32'h765412EF, 1'b0);

    run("err_lw_102", 1'b0, 32'h102, 32'h0, F_W, 32'h0, 1'b1);
    run("err_lh_101", 1'b0, 32'h101, 32'h0, F_H, 32'h0, 1'b1);
    run("err_sw_oor", 1'b1, 32'h10000, 32'h0, F_W, 32'h0, 1'b1);
    run("err_ld_011", 1'b0, 32'h100, 32'h0, 3'b011, 32'h0, 1'b1);
    run("err_sw_100", 1'b1, 32'h100, 32'h0, 3'b100, 32'h0, 1'b1);
    run("err_sh_103", 1'b1, 32'h103, 32'h0, F_H, 32'h0, 1'b1);
    run("lw_after_err", 1'b0, 32'h100, 32'h0, F_W, 32'h765412EF, 1'b0);

    bus.rsp_ready = 1'b0;
    start_req(1'b0, 32'h100, 32'h0, F_W);
    wait_rsp(rd, er, lat);
    check("bp_lat", 32'(lat), 32'(LAT));
    check("bp_rdata0", rd, 32'h765412EF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata", bus.rsp_rdata, 32'h765412EF);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      if (i == 1) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h100;
        bus.req_wdata  = 32'h0;
        bus.req_funct3 = F_W;
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    run("lw_after_bp", 1'b0, 32'h100, 32'h0, F_W, 32'h765412EF, 1'b0);

    run("sw_preload", 1'b1, 32'h200, 32'h0, F_W, 32'h0, 1'b0);
    start_req(1'b1, 32'h200, 32'h11111111, F_W);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_quiet", 32'(bus.rsp_valid), 32'd0);
    run("lw_after_rst", 1'b0, 32'h200, 32'h0, F_W, 32'h00000000, 1'b0);
    run("lw_keep_100", 1'b0, 32'h100, 32'h0, F_W, 32'h765412EF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
